score_bcd_arbiter: RTL and testbench



---
 rtl/score_bcd_arbiter.sv | 168 ++++++++++++++++
 tb/tb_score_bcd_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/score_bcd_arbiter.sv
// Three BCD score registers fed by a round-robin arbitrated serial BCD adder
// (one digit per cycle); displayed copies refresh only on the vblank rising edge.
module score_bcd_arbiter #(
    parameter int DIGITS  = 6,
    parameter int RST_PTR = 2
) (
    input  logic                  pclk,
    input  logic                  rst,
    input  logic [2:0]            req,
    input  logic [7:0]            add_val_0,
    input  logic [7:0]            add_val_1,
    input  logic [7:0]            add_val_2,
    input  logic                  clr,
    input  logic                  vblank,
    output logic [2:0]            ack,
    output logic                  busy,
    output logic [2:0]            overflow,
    output logic [4*DIGITS-1:0]   points,
    output logic [4*DIGITS-1:0]   ext_data_1,
    output logic [4*DIGITS-1:0]   ext_data_2
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {IDLE, ADD, WRITE} state_t;

    state_t          state, state_nxt;
    logic [1:0]      ptr, idx, grant;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    work [3];
    logic            vblank_d;
    logic [7:0]      sel_val;
    logic [4:0]      dsum;

    logic [W-1:0]    a_p0, b_p0, sum_p0;
    logic            carry_p0;

    function automatic logic [7:0] clamp_bcd(input logic [7:0] v);
        logic [3:0] hi, lo;
        hi = (v[7:4] > 4'd9) ? 4'd9 : v[7:4];
        lo = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
        return {hi, lo};
    endfunction

    // Returns {carry_out, digit}.
    function automatic logic [4:0] bcd_add(input logic [3:0] a, input logic [3:0] b,
                                           input logic c);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b} + {4'b0, c};
        if (s > 5'd9) return {1'b1, 4'(s - 5'd10)};
        else          return {1'b0, s[3:0]};
    endfunction

    function automatic logic [1:0] rr_pick(input logic [1:0] p, input logic [2:0] r);
        logic [1:0] g;
        logic       found;
        int         j;
        g     = 2'd0;
        found = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            j = (int'(p) + k) % 3;
            if (!found && r[2'(j)]) begin
                g     = 2'(j);
                found = 1'b1;
            end
        end
        return g;
    endfunction

    always_comb begin
        grant = rr_pick(ptr, req);
        case (grant)
            2'd0:    sel_val = add_val_0;
            2'd1:    sel_val = add_val_1;
            default: sel_val = add_val_2;
        endcase
    end

    assign dsum = bcd_add(a_p0[3:0], b_p0[3:0], carry_p0);

    always_comb begin
        state_nxt = state;
        ack       = 3'b000;
        busy      = 1'b0;
        case (state)
            IDLE:  if (|req) state_nxt = ADD;
            ADD: begin
                busy = 1'b1;
                if (cnt == CW'(DIGITS - 1)) state_nxt = WRITE;
            end
            WRITE: begin
                busy      = 1'b1;
                ack       = 3'b001 << idx;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // A clear cancels the in-flight add, including its ack.
        if (clr) begin
            state_nxt = IDLE;
            ack       = 3'b000;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= 2'(RST_PTR);
            idx        <= 2'd0;
            cnt        <= '0;
            work[0]    <= '0;
            work[1]    <= '0;
            work[2]    <= '0;
            overflow   <= 3'b000;
            vblank_d   <= 1'b0;
            points     <= '0;
            ext_data_1 <= '0;
            ext_data_2 <= '0;
        end else begin
            vblank_d <= vblank;
            // Display sees pre-update working values on the edge cycle.
            if (vblank && !vblank_d) begin
                points     <= work[0];
                ext_data_1 <= work[1];
                ext_data_2 <= work[2];
            end
            state <= state_nxt;
            if (clr) begin
                work[0]  <= '0;
                work[1]  <= '0;
                work[2]  <= '0;
                overflow <= 3'b000;
                cnt      <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        idx <= grant;
                        cnt <= '0;
                    end
                    ADD:  cnt <= cnt + 1'b1;
                    WRITE: begin
                        work[idx] <= carry_p0 ? ALL_NINES : sum_p0;
                        if (carry_p0) overflow[idx] <= 1'b1;
                        ptr <= idx;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Stage p0: operand capture in IDLE, one BCD digit per cycle in ADD.
    always_ff @(posedge pclk) begin
        if (state == IDLE) begin
            a_p0     <= work[grant];
            b_p0     <= {{(W-8){1'b0}}, clamp_bcd(sel_val)};
            carry_p0 <= 1'b0;
        end else if (state == ADD) begin
            a_p0     <= a_p0 >> 4;
            b_p0     <= b_p0 >> 4;
            sum_p0   <= {dsum[3:0], sum_p0[W-1:4]};
            carry_p0 <= dsum[4];
        end
    end

endmodule

// File: tb/tb_score_bcd_arbiter.sv
// Randomized bench for score_bcd_arbiter: a 6-digit and a 2-digit instance, each
// compared every cycle against a decimal-integer model of scores and arbitration.
module tb_score_bcd_arbiter;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic       rst_s    [2];
    logic       clr_s    [2];
    logic       vblank_s [2];
    logic [2:0] req_s    [2];
    logic [7:0] av_s     [2][3];
    logic [2:0] ack_o    [2];
    logic       busy_o   [2];
    logic [2:0] ovf_o    [2];
    logic [23:0] pa, p1, p2;
    logic [7:0]  qa, q1, q2;

    score_bcd_arbiter #(.DIGITS(6), .RST_PTR(2)) u_dut6 (
        .pclk(pclk), .rst(rst_s[0]), .req(req_s[0]),
        .add_val_0(av_s[0][0]), .add_val_1(av_s[0][1]), .add_val_2(av_s[0][2]),
        .clr(clr_s[0]), .vblank(vblank_s[0]), .ack(ack_o[0]), .busy(busy_o[0]),
        .overflow(ovf_o[0]), .points(pa), .ext_data_1(p1), .ext_data_2(p2)
    );

    score_bcd_arbiter #(.DIGITS(2), .RST_PTR(2)) u_dut2 (
        .pclk(pclk), .rst(rst_s[1]), .req(req_s[1]),
        .add_val_0(av_s[1][0]), .add_val_1(av_s[1][1]), .add_val_2(av_s[1][2]),
        .clr(clr_s[1]), .vblank(vblank_s[1]), .ack(ack_o[1]), .busy(busy_o[1]),
        .overflow(ovf_o[1]), .points(qa), .ext_data_1(q1), .ext_data_2(q2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: scores as plain decimal integers.
    int m_t   [2];
    int m_g   [2];
    int m_ptr [2];
    int m_op  [2];
    int m_sc  [2][3];
    int m_dsp [2][3];
    bit m_ovf [2][3];
    bit m_vbd [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int ndig(input int d);
        return (d == 0) ? 6 : 2;
    endfunction

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int clamp_dec(input logic [7:0] v);
        int hi, lo;
        hi = (int'(v[7:4]) > 9) ? 9 : int'(v[7:4]);
        lo = (int'(v[3:0]) > 9) ? 9 : int'(v[3:0]);
        return hi * 10 + lo;
    endfunction

    task automatic model_reset(input int d);
        m_t[d]   = 0;
        m_g[d]   = 0;
        m_ptr[d] = 2;
        m_op[d]  = 0;
        m_vbd[d] = 1'b0;
        for (int p = 0; p < 3; p++) begin
            m_sc[d][p]  = 0;
            m_dsp[d][p] = 0;
            m_ovf[d][p] = 1'b0;
        end
    endtask

    task automatic check_dut(input int d);
        logic [2:0]  e_ack;
        logic [23:0] g0, g1, g2;
        e_ack = (m_t[d] == ndig(d) + 1) ? (3'b001 << m_g[d]) : 3'b000;
        if (d == 0) begin
            g0 = pa; g1 = p1; g2 = p2;
        end else begin
            g0 = {16'b0, qa}; g1 = {16'b0, q1}; g2 = {16'b0, q2};
        end
        chk($sformatf("d%0d ack", d), 32'(ack_o[d]), 32'(e_ack));
        chk($sformatf("d%0d busy", d), 32'(busy_o[d]), 32'(m_t[d] != 0));
        chk($sformatf("d%0d overflow", d), 32'(ovf_o[d]),
            32'({m_ovf[d][2], m_ovf[d][1], m_ovf[d][0]}));
        chk($sformatf("d%0d points", d), 32'(g0), 32'(to_bcd(m_dsp[d][0])));
        chk($sformatf("d%0d ext_data_1", d), 32'(g1), 32'(to_bcd(m_dsp[d][1])));
        chk($sformatf("d%0d ext_data_2", d), 32'(g2), 32'(to_bcd(m_dsp[d][2])));
    endtask

    task automatic drive(input int d, input int cyc);
        rst_s[d] = (cyc < 3) || ($urandom_range(0, 399) == 0);
        clr_s[d] = ($urandom_range(0, 79) == 0);
        if ($urandom_range(0, 5) == 0) vblank_s[d] = ~vblank_s[d];
        for (int p = 0; p < 3; p++) begin
            if (req_s[d][p] && ack_o[d][p] === 1'b1) begin
                if ($urandom_range(0, 1) == 0) req_s[d][p] = 1'b0;
                else                           av_s[d][p] = 8'($urandom);
            end else if (!req_s[d][p] && $urandom_range(0, 3) == 0) begin
                req_s[d][p] = 1'b1;
                av_s[d][p]  = 8'($urandom);
            end
        end
    endtask

    task automatic model_step(input int d);
        int maxv, s, p;
        maxv = (d == 0) ? 999999 : 99;
        if (rst_s[d]) begin
            model_reset(d);
        end else begin
            if (vblank_s[d] && !m_vbd[d])
                for (int k = 0; k < 3; k++) m_dsp[d][k] = m_sc[d][k];
            m_vbd[d] = vblank_s[d];
            if (clr_s[d]) begin
                m_t[d] = 0;
                for (int k = 0; k < 3; k++) begin
                    m_sc[d][k]  = 0;
                    m_ovf[d][k] = 1'b0;
                end
            end else if (m_t[d] == 0) begin
                if (req_s[d] != 3'b000) begin
                    for (int k = 3; k >= 1; k--) begin
                        p = (m_ptr[d] + k) % 3;
                        if (req_s[d][p]) m_g[d] = p;
                    end
                    m_op[d] = clamp_dec(av_s[d][m_g[d]]);
                    m_t[d]  = 1;
                end
            end else if (m_t[d] <= ndig(d)) begin
                m_t[d]++;
            end else begin
                s = m_sc[d][m_g[d]] + m_op[d];
                if (s > maxv) begin
                    s = maxv;
                    m_ovf[d][m_g[d]] = 1'b1;
                end
                m_sc[d][m_g[d]] = s;
                m_ptr[d] = m_g[d];
                m_t[d]   = 0;
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_s[d]    = 1'b1;
            clr_s[d]    = 1'b0;
            vblank_s[d] = 1'b0;
            req_s[d]    = 3'b000;
            for (int p = 0; p < 3; p++) av_s[d][p] = 8'h00;
            model_reset(d);
        end
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge pclk);
            for (int d = 0; d < 2; d++) begin
                check_dut(d);
                drive(d, cyc);
                model_step(d);
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
